// File: rtl/hex_scroll_ctrl.sv
// Six-digit HEX0..HEX5 scroller: loadable character buffer, window scrolled at a fixed tick.
// Define HEX_SCROLL_BLINK_EN to make all digits blink while the scroll is held.
module hex_scroll_ctrl #(
  parameter int TICK_DIV = 12_500_000,
  parameter int MSG_MAX  = 16,
  parameter int AW       = 4
) (
  input  logic          CLOCK_50,
  input  logic          RST,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  input  logic [AW:0]   msg_len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_char,
  output logic [6:0]    HEX0,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX2,
  output logic [6:0]    HEX3,
  output logic [6:0]    HEX4,
  output logic [6:0]    HEX5,
  output logic          busy,
  output logic          wrap
);

  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pos_reg, pos_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [AW:0]   len_reg, len_next;
  logic          wrap_reg, wrap_next;
  logic          blank_all;
  logic [4:0]    msg_mem [MSG_MAX];

  // Six digits read concurrently, so the buffer is a register file rather than a RAM.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en)
      msg_mem[wr_addr] <= wr_char;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_reg <= IDLE;
      pos_reg   <= '0;
      tick_reg  <= '0;
      len_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      tick_reg  <= tick_next;
      len_reg   <= len_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Cycles that take a control pulse never count a tick; stop > start > pause.
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    tick_next  = tick_reg;
    len_next   = len_reg;
    wrap_next  = 1'b0;
    if (stop) begin
      state_next = IDLE;
      pos_next   = '0;
      tick_next  = '0;
    end else if (start) begin
      state_next = RUN;
      pos_next   = '0;
      tick_next  = '0;
      len_next   = (msg_len > (AW+1)'(MSG_MAX)) ? '0 : msg_len;
    end else if (pause && state_reg == RUN) begin
      state_next = HOLD;
    end else if (pause && state_reg == HOLD) begin
      state_next = RUN;
    end else if (state_reg == RUN) begin
      if (tick_reg == TW'(TICK_DIV - 1)) begin
        tick_next = '0;
        if (len_reg != '0) begin
          if ({1'b0, pos_reg} == len_reg - (AW+1)'(1)) begin
            pos_next  = '0;
            wrap_next = 1'b1;
          end else begin
            pos_next = pos_reg + AW'(1);
          end
        end
      end else begin
        tick_next = tick_reg + TW'(1);
      end
    end
  end

`ifdef HEX_SCROLL_BLINK_EN
  logic [TW-1:0] blink_cnt_reg;
  logic          blink_vis_reg;

  // Phase restarts on every HOLD entry so the first half-period is visible.
  always_ff @(posedge CLOCK_50) begin
    if (RST || state_reg != HOLD) begin
      blink_cnt_reg <= '0;
      blink_vis_reg <= 1'b1;
    end else if (blink_cnt_reg == TW'(TICK_DIV - 1)) begin
      blink_cnt_reg <= '0;
      blink_vis_reg <= ~blink_vis_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + TW'(1);
    end
  end

  assign blank_all = (state_reg == IDLE) || (len_reg == '0) ||
                     (state_reg == HOLD && !blink_vis_reg);
`else
  assign blank_all = (state_reg == IDLE) || (len_reg == '0);
`endif

  // (pos + k) mod len by repeated subtraction; five passes cover len == 1 with k == 5.
  function automatic logic [AW-1:0] wrap_index(input logic [AW-1:0] pos, input int k,
                                               input logic [AW:0] len);
    logic [AW:0] s;
    s = {1'b0, pos} + (AW+1)'(k);
    for (int i = 0; i < 5; i++)
      if (len != '0 && s >= len)
        s = s - len;
    return s[AW-1:0];
  endfunction

  function automatic logic [6:0] seg7(input logic [4:0] c);
    case (c)
      5'd0:  seg7 = 7'h40;  5'd1:  seg7 = 7'h79;  5'd2:  seg7 = 7'h24;  5'd3:  seg7 = 7'h30;
      5'd4:  seg7 = 7'h19;  5'd5:  seg7 = 7'h12;  5'd6:  seg7 = 7'h02;  5'd7:  seg7 = 7'h78;
      5'd8:  seg7 = 7'h00;  5'd9:  seg7 = 7'h10;  5'd10: seg7 = 7'h08;  5'd11: seg7 = 7'h03;
      5'd12: seg7 = 7'h46;  5'd13: seg7 = 7'h21;  5'd14: seg7 = 7'h06;  5'd15: seg7 = 7'h0E;
      5'd17: seg7 = 7'h3F;  5'd18: seg7 = 7'h09;  5'd19: seg7 = 7'h47;  5'd20: seg7 = 7'h0C;
      5'd21: seg7 = 7'h41;  5'd22: seg7 = 7'h2F;  5'd23: seg7 = 7'h2B;  5'd24: seg7 = 7'h23;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Digit gi shows window offset gi; offset 0 is the leftmost display (HEX5).
  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    logic [AW-1:0] idx;
    logic [6:0]    seg_reg;

    assign idx = wrap_index(pos_reg, gi, len_reg);

    always_ff @(posedge CLOCK_50) begin
      if (RST || blank_all)
        seg_reg <= 7'h7F;
      else
        seg_reg <= seg7(msg_mem[idx]);
    end
  end

  assign HEX5 = g_digit[0].seg_reg;
  assign HEX4 = g_digit[1].seg_reg;
  assign HEX3 = g_digit[2].seg_reg;
  assign HEX2 = g_digit[3].seg_reg;
  assign HEX1 = g_digit[4].seg_reg;
  assign HEX0 = g_digit[5].seg_reg;
  assign busy = (state_reg != IDLE);
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed self-checking bench for hex_scroll_ctrl with TICK_DIV=4, MSG_MAX=16.
module tb_hex_scroll_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [4:0] msg_len = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [4:0] wr_char = '0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       busy, wrap;

  hex_scroll_ctrl #(.TICK_DIV(4), .MSG_MAX(16), .AW(4)) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .start(start), .pause(pause), .stop(stop),
    .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .busy(busy), .wrap(wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  localparam logic [6:0] SEG [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h7F, 7'h3F, 7'h09, 7'h47, 7'h0C, 7'h41, 7'h2F, 7'h2B,
    7'h23, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [41:0] BLANK6 = {6{7'h7F}};
  localparam logic [41:0] HM1_0  = {7'h09, 7'h3F, 7'h79, 7'h09, 7'h3F, 7'h79};
  localparam logic [41:0] HM1_1  = {7'h3F, 7'h79, 7'h09, 7'h3F, 7'h79, 7'h09};

  logic [41:0] hexw;
  assign hexw = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  logic [4:0] tb_msg [16];
  int errors = 0;
  int checks = 0;
  int wrap_cnt = 0;
  int w0;

  always @(posedge CLOCK_50) if (wrap) wrap_cnt <= wrap_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wr(input int a, input logic [4:0] c);
    wr_en = 1'b1; wr_addr = 4'(a); wr_char = c;
    tick(1);
    wr_en = 1'b0;
    tb_msg[a] = c;
  endtask

  task automatic pulse_start(input logic [4:0] len);
    msg_len = len; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  function automatic logic [41:0] exp_window(input int p, input int len);
    logic [41:0] w;
    w = BLANK6;
    if (len != 0)
      for (int k = 0; k < 6; k++)
        w[41-7*k -: 7] = SEG[tb_msg[(p + k) % len]];
    return w;
  endfunction

  initial begin
    // reset and idle blank
    tick(2);
    RST = 1'b0;
    check("reset_hex", 64'(hexw), 64'(BLANK6));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wrap", 64'(wrap), 64'd0);
    for (int i = 0; i < 8; i++) wr(i, 5'(i));
    tick(2);
    check("idle_blank_loaded", 64'(hexw), 64'(BLANK6));

    // eight-char scroll with one wrap per lap
    pulse_start(5'd8);
    check("run_busy", 64'(busy), 64'd1);
    tick(1);
    check("len8_pos0", 64'(hexw), 64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
    w0 = wrap_cnt;
    for (int s = 1; s <= 8; s++) begin
      if (s == 8) begin
        tick(3);
        check("wrap_pulse_high", 64'(wrap), 64'd1);
        tick(1);
      end else begin
        tick(4);
        check("wrap_low_midlap", 64'(wrap), 64'd0);
      end
      check($sformatf("len8_step%0d", s), 64'(hexw), 64'(exp_window(s % 8, 8)));
    end
    check("len8_wrap_count", 64'(wrap_cnt - w0), 64'd1);

    // three-char message repeats across six digits
    stop = 1'b1; tick(1); stop = 1'b0;
    wr(0, 5'd18); wr(1, 5'd17); wr(2, 5'd1);
    pulse_start(5'd3);
    tick(1);
    check("len3_pos0", 64'(hexw), 64'(HM1_0));
    w0 = wrap_cnt;
    tick(24);
    check("len3_wrap_count", 64'(wrap_cnt - w0), 64'd2);
    check("len3_back_pos0", 64'(hexw), 64'(HM1_0));

    // pause with tick_cnt=1, hold 20 cycles, resume needs 3 more counts
    pause = 1'b1; tick(1); pause = 1'b0;
    check("hold_busy", 64'(busy), 64'd1);
    tick(5);
`ifdef HEX_SCROLL_BLINK_EN
    check("hold_blink_blank", 64'(hexw), 64'(BLANK6));
`else
    check("hold_steady", 64'(hexw), 64'(HM1_0));
`endif
    tick(15);
    check("hold_frozen_20", 64'(hexw), 64'(HM1_0));
    pause = 1'b1; tick(1); pause = 1'b0;
    tick(3);
    check("resume_not_yet", 64'(hexw), 64'(HM1_0));
    tick(1);
    check("resume_step", 64'(hexw), 64'(HM1_1));

    // coincident pulses
    start = 1'b1; stop = 1'b1; pause = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    check("all3_busy", 64'(busy), 64'd0);
    tick(1);
    check("all3_blank", 64'(hexw), 64'(BLANK6));
    msg_len = 5'd3; start = 1'b1; pause = 1'b1;
    tick(1);
    start = 1'b0; pause = 1'b0;
    check("start_pause_busy", 64'(busy), 64'd1);
    tick(1);
    check("start_pause_pos0", 64'(hexw), 64'(HM1_0));
    tick(4);
    check("start_pause_runs", 64'(hexw), 64'(HM1_1));

    // live write to the slot on HEX3
    pulse_start(5'd8);
    tick(1);
    check("live_before", 64'(HEX3), 64'h79);
    wr(2, 5'd20);
    check("live_plus1", 64'(HEX3), 64'h79);
    tick(1);
    check("live_plus2", 64'(HEX3), 64'h0C);
    check("live_window", 64'(hexw), 64'(exp_window(0, 8)));

    // zero and out-of-range lengths stay blank with no wrap
    pulse_start(5'd0);
    check("len0_busy", 64'(busy), 64'd1);
    w0 = wrap_cnt;
    tick(13);
    check("len0_blank", 64'(hexw), 64'(BLANK6));
    check("len0_no_wrap", 64'(wrap_cnt - w0), 64'd0);
    pulse_start(5'd17);
    tick(9);
    check("len17_blank", 64'(hexw), 64'(BLANK6));
    check("len17_no_wrap", 64'(wrap_cnt - w0), 64'd0);

    // reset mid-scroll
    pulse_start(5'd8);
    tick(6);
    RST = 1'b1; tick(1); RST = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hex", 64'(hexw), 64'(BLANK6));
    tick(3);
    check("midrst_idle", 64'(hexw), 64'(BLANK6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
